// File: rtl/rf_arb_pkg.sv
// Shared widths, the PC index and the write-source encoding for the
// register-file write arbiter.
package rf_arb_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 4;
  localparam int unsigned NREG = 15;

  localparam logic [AW-1:0] PC_IDX = 4'd15;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_M    = 2'd2,
    SRC_F    = 2'd3
  } src_e;

  // The PC is not a banked register and never lands in the register file.
  function automatic logic is_pc(input logic [AW-1:0] addr);
    return (addr == PC_IDX);
  endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bundle of writer, decode and register-file signals around rf_write_arbiter.
// The arbiter uses the slave modport; the surrounding pipeline uses master.
interface rf_write_arbiter_if;
  import rf_arb_pkg::*;

  logic          WB_WE;
  logic [AW-1:0] WB_A;
  logic [DW-1:0] WB_WD;
  logic          M_VALID;
  logic [AW-1:0] M_A;
  logic [DW-1:0] M_WD;
  logic          M_READY;
  logic          F_VALID;
  logic [AW-1:0] F_A;
  logic [DW-1:0] F_WD;
  logic          F_READY;
  logic          ISSUE_V;
  logic [AW-1:0] ISSUE_A;
  logic [AW-1:0] RA1D;
  logic [AW-1:0] RA2D;
  logic          HAZ1;
  logic          HAZ2;
  logic          WE3;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic          WB_STALL;
  logic          DROP_ERR;

  modport slave (
    input  WB_WE, WB_A, WB_WD,
    input  M_VALID, M_A, M_WD,
    input  F_VALID, F_A, F_WD,
    input  ISSUE_V, ISSUE_A, RA1D, RA2D,
    output M_READY, F_READY, HAZ1, HAZ2,
    output WE3, A3, WD3, WB_STALL, DROP_ERR
  );

  modport master (
    output WB_WE, WB_A, WB_WD,
    output M_VALID, M_A, M_WD,
    output F_VALID, F_A, F_WD,
    output ISSUE_V, ISSUE_A, RA1D, RA2D,
    input  M_READY, F_READY, HAZ1, HAZ2,
    input  WE3, A3, WD3, WB_STALL, DROP_ERR
  );

endinterface

// File: rtl/rf_skid_buf.sv
// One-entry result buffer for a slow writer: accepts a result only when empty
// and empties when the arbiter grants it.
module rf_skid_buf
  import rf_arb_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  input  logic [DW-1:0] in_data,
  input  logic          clr,
  output logic          full,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  logic          full_d, full_q;
  logic [AW-1:0] addr_d, addr_q;
  logic [DW-1:0] data_d, data_q;

  // A grant only reaches a full buffer and a load only an empty one, so they never collide.
  always_comb begin
    full_d = full_q;
    addr_d = addr_q;
    data_d = data_q;
    if (clr) begin
      full_d = 1'b0;
    end else if (in_valid && !full_q) begin
      full_d = 1'b1;
      addr_d = in_addr;
      data_d = in_data;
    end else begin
      full_d = full_q;
    end
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign full = full_q;
  assign addr = addr_q;
  assign data = data_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter for writeback, multiplier and float results,
// with a pending-destination scoreboard. Starvation override: RF_ARB_STARVE_EN.
module rf_write_arbiter
  import rf_arb_pkg::*;
`ifdef RF_ARB_STARVE_EN
#(
  parameter int unsigned STARVE_LIMIT = 4
)
`endif
(
  input  logic              CLK,
  input  logic              RESETn,
  rf_write_arbiter_if.slave bus
);

  logic          m_full_s, f_full_s;
  logic [AW-1:0] m_addr_s, f_addr_s;
  logic [DW-1:0] m_data_s, f_data_s;
  src_e          grant_s, rr_pick_s;
  logic          slow_grant_s;
  logic [AW-1:0] win_a_s;
  logic [DW-1:0] win_wd_s;
  logic          wb_stall_s;

  logic          we_d, we_q;
  logic [AW-1:0] a_d, a_q;
  logic [DW-1:0] wd_d, wd_q;
  logic          drop_d, drop_q;
  logic          rr_d, rr_q;
  logic [NREG-1:0] pend_d, pend_q;
  logic [NREG-1:0] clr_mask_s, set_mask_s;
  logic [NREG:0]   pend_ext_s;

  rf_skid_buf u_m_buf (
    .clk      (CLK),
    .rst_n    (RESETn),
    .in_valid (bus.M_VALID),
    .in_addr  (bus.M_A),
    .in_data  (bus.M_WD),
    .clr      (grant_s == SRC_M),
    .full     (m_full_s),
    .addr     (m_addr_s),
    .data     (m_data_s)
  );

  rf_skid_buf u_f_buf (
    .clk      (CLK),
    .rst_n    (RESETn),
    .in_valid (bus.F_VALID),
    .in_addr  (bus.F_A),
    .in_data  (bus.F_WD),
    .clr      (grant_s == SRC_F),
    .full     (f_full_s),
    .addr     (f_addr_s),
    .data     (f_data_s)
  );

  // Round-robin choice between the slow sources; rr_q=1 prefers F.
  always_comb begin
    if (m_full_s && f_full_s) begin
      rr_pick_s = rr_q ? SRC_F : SRC_M;
    end else if (m_full_s) begin
      rr_pick_s = SRC_M;
    end else if (f_full_s) begin
      rr_pick_s = SRC_F;
    end else begin
      rr_pick_s = SRC_NONE;
    end
  end

`ifdef RF_ARB_STARVE_EN
  localparam int unsigned   CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] m_cnt_d, m_cnt_q, f_cnt_d, f_cnt_q;
  logic          m_starved_s, f_starved_s;

  assign m_starved_s = (m_cnt_q >= LIMIT);
  assign f_starved_s = (f_cnt_q >= LIMIT);

  // Lost-cycle counters saturate at the limit so the loser of a double starvation stays starved.
  always_comb begin
    m_cnt_d = m_cnt_q;
    f_cnt_d = f_cnt_q;
    if (!m_full_s || (grant_s == SRC_M)) begin
      m_cnt_d = '0;
    end else if (m_cnt_q != LIMIT) begin
      m_cnt_d = m_cnt_q + CW'(1);
    end else begin
      m_cnt_d = m_cnt_q;
    end
    if (!f_full_s || (grant_s == SRC_F)) begin
      f_cnt_d = '0;
    end else if (f_cnt_q != LIMIT) begin
      f_cnt_d = f_cnt_q + CW'(1);
    end else begin
      f_cnt_d = f_cnt_q;
    end
  end

  // Starvation counter registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      m_cnt_q <= '0;
      f_cnt_q <= '0;
    end else begin
      m_cnt_q <= m_cnt_d;
      f_cnt_q <= f_cnt_d;
    end
  end

  // A starved slow source overrides writeback; rr breaks a double starvation.
  always_comb begin
    if (m_starved_s && f_starved_s) begin
      grant_s = rr_pick_s;
    end else if (m_starved_s) begin
      grant_s = SRC_M;
    end else if (f_starved_s) begin
      grant_s = SRC_F;
    end else if (bus.WB_WE) begin
      grant_s = SRC_WB;
    end else begin
      grant_s = rr_pick_s;
    end
  end

  assign wb_stall_s = m_starved_s | f_starved_s;
`else
  // Writeback always wins; slow sources share the leftover cycles.
  always_comb begin
    if (bus.WB_WE) begin
      grant_s = SRC_WB;
    end else begin
      grant_s = rr_pick_s;
    end
  end

  assign wb_stall_s = 1'b0;
`endif

  assign slow_grant_s = (grant_s == SRC_M) || (grant_s == SRC_F);

  // Winner address/data mux.
  always_comb begin
    win_a_s  = '0;
    win_wd_s = '0;
    case (grant_s)
      SRC_WB: begin
        win_a_s  = bus.WB_A;
        win_wd_s = bus.WB_WD;
      end
      SRC_M: begin
        win_a_s  = m_addr_s;
        win_wd_s = m_data_s;
      end
      SRC_F: begin
        win_a_s  = f_addr_s;
        win_wd_s = f_data_s;
      end
      default: begin
        win_a_s  = '0;
        win_wd_s = '0;
      end
    endcase
  end

  // Write controls, sticky drop flag and rr pointer; a PC-destined grant is consumed without a write.
  always_comb begin
    we_d   = 1'b0;
    a_d    = a_q;
    wd_d   = wd_q;
    drop_d = drop_q;
    rr_d   = rr_q;
    if ((grant_s != SRC_NONE) && !is_pc(win_a_s)) begin
      we_d = 1'b1;
      a_d  = win_a_s;
      wd_d = win_wd_s;
    end else begin
      we_d = 1'b0;
    end
    if (slow_grant_s && is_pc(win_a_s)) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
    if (grant_s == SRC_M) begin
      rr_d = 1'b1;
    end else if (grant_s == SRC_F) begin
      rr_d = 1'b0;
    end else begin
      rr_d = rr_q;
    end
  end

  // Scoreboard update; a same-edge issue to the retiring register keeps it pending.
  always_comb begin
    clr_mask_s = '0;
    set_mask_s = '0;
    if (slow_grant_s && !is_pc(win_a_s)) begin
      clr_mask_s[win_a_s] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
    if (bus.ISSUE_V && !is_pc(bus.ISSUE_A)) begin
      set_mask_s[bus.ISSUE_A] = 1'b1;
    end else begin
      set_mask_s = '0;
    end
    pend_d = (pend_q & ~clr_mask_s) | set_mask_s;
  end

  // Output stage and scoreboard registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      we_q   <= 1'b0;
      a_q    <= '0;
      wd_q   <= '0;
      drop_q <= 1'b0;
      rr_q   <= 1'b0;
      pend_q <= '0;
    end else begin
      we_q   <= we_d;
      a_q    <= a_d;
      wd_q   <= wd_d;
      drop_q <= drop_d;
      rr_q   <= rr_d;
      pend_q <= pend_d;
    end
  end

  assign pend_ext_s   = {1'b0, pend_q};
  assign bus.HAZ1     = pend_ext_s[bus.RA1D];
  assign bus.HAZ2     = pend_ext_s[bus.RA2D];
  assign bus.M_READY  = ~m_full_s;
  assign bus.F_READY  = ~f_full_s;
  assign bus.WE3      = we_q;
  assign bus.A3       = a_q;
  assign bus.WD3      = wd_q;
  assign bus.WB_STALL = wb_stall_s;
  assign bus.DROP_ERR = drop_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, hand-written
// starvation/reset sequences and randomized traffic against a behavioural model.
module tb_rf_write_arbiter;
  import rf_arb_pkg::*;

  localparam int LIM = 4;

  logic CLK = 1'b0;
  logic RESETn;
  always #5 CLK = ~CLK;

  rf_write_arbiter_if bus ();

  rf_write_arbiter dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus)
  );

  int tests  = 0;
  int failed = 0;

  typedef struct {
    logic        wb_we;
    logic [3:0]  wb_a;
    logic [31:0] wb_wd;
    logic        m_v;
    logic [3:0]  m_a;
    logic [31:0] m_wd;
    logic        f_v;
    logic [3:0]  f_a;
    logic [31:0] f_wd;
    logic        iss_v;
    logic [3:0]  iss_a;
    logic        e_we;
    logic [3:0]  e_a;
    logic [31:0] e_wd;
    logic        e_mr;
    logic        e_fr;
    logic        e_haz1;
    logic        e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic wb_we, input logic [3:0] wb_a, input logic [31:0] wb_wd,
                      input logic m_v, input logic [3:0] m_a, input logic [31:0] m_wd,
                      input logic f_v, input logic [3:0] f_a, input logic [31:0] f_wd,
                      input logic iss_v, input logic [3:0] iss_a,
                      input logic e_we, input logic [3:0] e_a, input logic [31:0] e_wd,
                      input logic e_mr, input logic e_fr, input logic e_haz1, input logic e_drop);
    vec_t v;
    v = '{wb_we, wb_a, wb_wd, m_v, m_a, m_wd, f_v, f_a, f_wd, iss_v, iss_a,
          e_we, e_a, e_wd, e_mr, e_fr, e_haz1, e_drop};
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus.WB_WE   = 1'b0; bus.WB_A = 4'd0; bus.WB_WD = 32'd0;
    bus.M_VALID = 1'b0; bus.M_A  = 4'd0; bus.M_WD  = 32'd0;
    bus.F_VALID = 1'b0; bus.F_A  = 4'd0; bus.F_WD  = 32'd0;
    bus.ISSUE_V = 1'b0; bus.ISSUE_A = 4'd0;
    bus.RA1D    = 4'd7; bus.RA2D = 4'd15;
  endtask

  // Behavioural model: buffers, preference, pending set and write outputs.
  bit          mdl_mfull, mdl_ffull, mdl_pref_f, mdl_we, mdl_drop;
  logic [3:0]  mdl_ma, mdl_fa, mdl_a;
  logic [31:0] mdl_md, mdl_fd, mdl_wd;
  bit [15:0]   mdl_pend;
  int          mdl_mcnt, mdl_fcnt;

  task automatic model_reset();
    mdl_mfull = 0; mdl_ffull = 0; mdl_pref_f = 0; mdl_we = 0; mdl_drop = 0;
    mdl_ma = 4'd0; mdl_fa = 4'd0; mdl_a = 4'd0;
    mdl_md = 32'd0; mdl_fd = 32'd0; mdl_wd = 32'd0;
    mdl_pend = 16'd0; mdl_mcnt = 0; mdl_fcnt = 0;
  endtask

  task automatic model_edge();
    int win;  // 0 none, 1 WB, 2 M, 3 F
    logic [3:0]  wa;
    logic [31:0] wd;
    bit mf, ff, m_st, f_st;
    mf = mdl_mfull;
    ff = mdl_ffull;
`ifdef RF_ARB_STARVE_EN
    m_st = (mdl_mcnt >= LIM);
    f_st = (mdl_fcnt >= LIM);
`else
    m_st = 0;
    f_st = 0;
`endif
    if (m_st && f_st)       win = mdl_pref_f ? 3 : 2;
    else if (m_st)          win = 2;
    else if (f_st)          win = 3;
    else if (bus.WB_WE)     win = 1;
    else if (mf && ff)      win = mdl_pref_f ? 3 : 2;
    else if (mf)            win = 2;
    else if (ff)            win = 3;
    else                    win = 0;
    wa = 4'd0;
    wd = 32'd0;
    if (win == 1) begin wa = bus.WB_A; wd = bus.WB_WD; end
    if (win == 2) begin wa = mdl_ma;   wd = mdl_md;    end
    if (win == 3) begin wa = mdl_fa;   wd = mdl_fd;    end
    mdl_we = 0;
    if (win != 0) begin
      if (wa != 4'd15) begin
        mdl_we = 1; mdl_a = wa; mdl_wd = wd;
      end else if (win >= 2) begin
        mdl_drop = 1;
      end
    end
    if (win == 2) mdl_pref_f = 1;
    if (win == 3) mdl_pref_f = 0;
    if (win >= 2 && wa != 4'd15) mdl_pend[wa] = 0;
    if (bus.ISSUE_V && bus.ISSUE_A != 4'd15) mdl_pend[bus.ISSUE_A] = 1;
    mdl_mcnt = (!mf || win == 2) ? 0 : mdl_mcnt + 1;
    mdl_fcnt = (!ff || win == 3) ? 0 : mdl_fcnt + 1;
    if (win == 2) mdl_mfull = 0;
    if (win == 3) mdl_ffull = 0;
    if (bus.M_VALID && !mf) begin mdl_mfull = 1; mdl_ma = bus.M_A; mdl_md = bus.M_WD; end
    if (bus.F_VALID && !ff) begin mdl_ffull = 1; mdl_fa = bus.F_A; mdl_fd = bus.F_WD; end
  endtask

  task automatic model_check();
    bit stall;
`ifdef RF_ARB_STARVE_EN
    stall = (mdl_mcnt >= LIM) || (mdl_fcnt >= LIM);
`else
    stall = 0;
`endif
    chk("rnd_we3",   bus.WE3,      mdl_we);
    chk("rnd_a3",    bus.A3,       mdl_a);
    chk("rnd_wd3",   bus.WD3,      mdl_wd);
    chk("rnd_mrdy",  bus.M_READY,  !mdl_mfull);
    chk("rnd_frdy",  bus.F_READY,  !mdl_ffull);
    chk("rnd_haz1",  bus.HAZ1,     mdl_pend[bus.RA1D]);
    chk("rnd_haz2",  bus.HAZ2,     mdl_pend[bus.RA2D]);
    chk("rnd_drop",  bus.DROP_ERR, mdl_drop);
    chk("rnd_stall", bus.WB_STALL, stall);
  endtask

  initial begin
    bit macro_on;
    int wb_pct;
`ifdef RF_ARB_STARVE_EN
    macro_on = 1;
`else
    macro_on = 0;
`endif
    drive_idle();
    RESETn = 1'b0;

    // Directed vectors: inputs before an edge, expected outputs after it (RA1D=7, RA2D=15).
    //    wb  a      wd          m  a      wd          f  a     wd         iss a     we a      wd         mr fr h1 dr
    addv(1, 4'd3,  32'h1234, 0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 1, 4'd3, 32'h1234, 1, 1, 0, 0);
    addv(0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 0, 4'd3, 32'h1234, 1, 1, 0, 0);
    addv(0, 4'd0,  32'h0,    1, 4'd5,  32'hAA,   1, 4'd6, 32'hBB, 0, 4'd0, 0, 4'd3, 32'h1234, 0, 0, 0, 0);
    addv(0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 1, 4'd5, 32'hAA,   1, 0, 0, 0);
    addv(0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 1, 4'd6, 32'hBB,   1, 1, 0, 0);
    addv(0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 0, 4'd6, 32'hBB,   1, 1, 0, 0);
    addv(0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  1, 4'd7, 0, 4'd6, 32'hBB,   1, 1, 1, 0);
    addv(0, 4'd0,  32'h0,    1, 4'd7,  32'h77,   0, 4'd0, 32'h0,  0, 4'd0, 0, 4'd6, 32'hBB,   0, 1, 1, 0);
    addv(0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 1, 4'd7, 32'h77,   1, 1, 0, 0);
    addv(0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  1, 4'd7, 0, 4'd7, 32'h77,   1, 1, 1, 0);
    addv(0, 4'd0,  32'h0,    1, 4'd7,  32'h78,   0, 4'd0, 32'h0,  0, 4'd0, 0, 4'd7, 32'h77,   0, 1, 1, 0);
    addv(0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  1, 4'd7, 1, 4'd7, 32'h78,   1, 1, 1, 0);
    addv(0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 0, 4'd7, 32'h78,   1, 1, 1, 0);
    addv(0, 4'd0,  32'h0,    1, 4'd15, 32'hDEAD, 0, 4'd0, 32'h0,  0, 4'd0, 0, 4'd7, 32'h78,   0, 1, 1, 0);
    addv(0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 0, 4'd7, 32'h78,   1, 1, 1, 1);
    addv(1, 4'd15, 32'h55,   0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 0, 4'd7, 32'h78,   1, 1, 1, 1);
    addv(1, 4'd2,  32'h22,   0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 1, 4'd2, 32'h22,   1, 1, 1, 1);
    addv(1, 4'd4,  32'h44,   1, 4'd1,  32'h11,   0, 4'd0, 32'h0,  0, 4'd0, 1, 4'd4, 32'h44,   0, 1, 1, 1);
    addv(1, 4'd8,  32'h88,   0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 1, 4'd8, 32'h88,   0, 1, 1, 1);
    addv(0, 4'd0,  32'h0,    0, 4'd0,  32'h0,    0, 4'd0, 32'h0,  0, 4'd0, 1, 4'd1, 32'h11,   1, 1, 1, 1);

    repeat (2) @(posedge CLK);
    #1;
    chk("rst_we3",   bus.WE3,      1'b0);
    chk("rst_a3",    bus.A3,       4'd0);
    chk("rst_wd3",   bus.WD3,      32'd0);
    chk("rst_mrdy",  bus.M_READY,  1'b1);
    chk("rst_frdy",  bus.F_READY,  1'b1);
    chk("rst_drop",  bus.DROP_ERR, 1'b0);
    chk("rst_stall", bus.WB_STALL, 1'b0);
    chk("rst_haz1",  bus.HAZ1,     1'b0);
    @(negedge CLK);
    RESETn = 1'b1;

    foreach (vecs[i]) begin
      bus.WB_WE   = vecs[i].wb_we; bus.WB_A = vecs[i].wb_a; bus.WB_WD = vecs[i].wb_wd;
      bus.M_VALID = vecs[i].m_v;   bus.M_A  = vecs[i].m_a;  bus.M_WD  = vecs[i].m_wd;
      bus.F_VALID = vecs[i].f_v;   bus.F_A  = vecs[i].f_a;  bus.F_WD  = vecs[i].f_wd;
      bus.ISSUE_V = vecs[i].iss_v; bus.ISSUE_A = vecs[i].iss_a;
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_we3", i),   bus.WE3,      vecs[i].e_we);
      chk($sformatf("v%0d_a3", i),    bus.A3,       vecs[i].e_a);
      chk($sformatf("v%0d_wd3", i),   bus.WD3,      vecs[i].e_wd);
      chk($sformatf("v%0d_mrdy", i),  bus.M_READY,  vecs[i].e_mr);
      chk($sformatf("v%0d_frdy", i),  bus.F_READY,  vecs[i].e_fr);
      chk($sformatf("v%0d_haz1", i),  bus.HAZ1,     vecs[i].e_haz1);
      chk($sformatf("v%0d_haz2", i),  bus.HAZ2,     1'b0);
      chk($sformatf("v%0d_drop", i),  bus.DROP_ERR, vecs[i].e_drop);
      chk($sformatf("v%0d_stall", i), bus.WB_STALL, 1'b0);
    end

    // Writeback held for many cycles while M (reg 9) waits in its buffer.
    drive_idle();
    bus.M_VALID = 1'b1; bus.M_A = 4'd9; bus.M_WD = 32'h99;
    bus.WB_WE = 1'b1; bus.WB_A = 4'd10;
    for (int k = 0; k <= 10; k++) begin
      logic [3:0]  ea;
      logic [31:0] ed;
      logic        emr, est;
      bus.WB_WD = 32'h1000 + k;
      @(posedge CLK);
      #1;
      bus.M_VALID = 1'b0;
      ea = 4'd10; ed = 32'h1000 + k; emr = 1'b0; est = 1'b0;
      if (macro_on) begin
        if (k == 4) est = 1'b1;
        if (k == 5) begin ea = 4'd9; ed = 32'h99; end
        if (k >= 5) emr = 1'b1;
      end
      chk($sformatf("stv%0d_we3", k),   bus.WE3,      1'b1);
      chk($sformatf("stv%0d_a3", k),    bus.A3,       ea);
      chk($sformatf("stv%0d_wd3", k),   bus.WD3,      ed);
      chk($sformatf("stv%0d_mrdy", k),  bus.M_READY,  emr);
      chk($sformatf("stv%0d_stall", k), bus.WB_STALL, est);
    end
    bus.WB_WE = 1'b0;
    @(posedge CLK);
    #1;
    chk("stv_end_we3",  bus.WE3,     macro_on ? 1'b0 : 1'b1);
    chk("stv_end_a3",   bus.A3,      macro_on ? 4'd10 : 4'd9);
    chk("stv_end_mrdy", bus.M_READY, 1'b1);

    // Asynchronous reset mid-cycle with both buffers full and reg 7 pending.
    bus.WB_WE = 1'b1; bus.WB_A = 4'd3; bus.WB_WD = 32'h5;
    bus.M_VALID = 1'b1; bus.M_A = 4'd11; bus.M_WD = 32'hB;
    bus.F_VALID = 1'b1; bus.F_A = 4'd12; bus.F_WD = 32'hC;
    bus.ISSUE_V = 1'b1; bus.ISSUE_A = 4'd7;
    @(posedge CLK);
    #1;
    drive_idle();
    chk("pre_rst_mrdy", bus.M_READY, 1'b0);
    chk("pre_rst_frdy", bus.F_READY, 1'b0);
    chk("pre_rst_haz1", bus.HAZ1,    1'b1);
    chk("pre_rst_we3",  bus.WE3,     1'b1);
    #2;
    RESETn = 1'b0;
    #1;
    chk("arst_mrdy", bus.M_READY,  1'b1);
    chk("arst_frdy", bus.F_READY,  1'b1);
    chk("arst_we3",  bus.WE3,      1'b0);
    chk("arst_a3",   bus.A3,       4'd0);
    chk("arst_haz1", bus.HAZ1,     1'b0);
    chk("arst_drop", bus.DROP_ERR, 1'b0);
    @(negedge CLK);
    RESETn = 1'b1;
    model_reset();

    // Randomized traffic with alternating writeback-heavy and light phases.
    for (int c = 0; c < 3000; c++) begin
      wb_pct = ((c % 200) < 100) ? 85 : 30;
      bus.WB_WE   = ($urandom_range(0, 99) < wb_pct);
      bus.WB_A    = 4'($urandom_range(0, 15));
      bus.WB_WD   = $urandom;
      bus.M_VALID = ($urandom_range(0, 1) == 1);
      bus.M_A     = 4'($urandom_range(0, 15));
      bus.M_WD    = $urandom;
      bus.F_VALID = ($urandom_range(0, 1) == 1);
      bus.F_A     = 4'($urandom_range(0, 15));
      bus.F_WD    = $urandom;
      bus.ISSUE_V = ($urandom_range(0, 9) < 3);
      bus.ISSUE_A = 4'($urandom_range(0, 15));
      bus.RA1D    = 4'($urandom_range(0, 15));
      bus.RA2D    = 4'($urandom_range(0, 15));
      model_edge();
      @(posedge CLK);
      #1;
      model_check();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Sequences the single register-file write port (WE3/A3/WD3) among three writers: pipeline writeback (WB), multi-cycle multiplier (M) and float unit (F).
- Buffers M/F results in one-entry skid buffers, arbitrates one write per cycle and drives registered write controls to the register file, which writes on the following negedge.
- Keeps a pending-destination scoreboard so decode can detect RAW hazards on outstanding M/F results.

Parameters:
- DW, 32, data width
- AW, 4, register address width
- NREG, 15, banked registers (index 15 = PC, not banked)
- STARVE_LIMIT, 4, consecutive lost cycles before a slow source overrides WB (macro only)

Ports:
- CLK  in  1  clock, rising-edge logic
- RESETn  in  1  asynchronous, active-low reset
- WB_WE  in  1  writeback write request
- WB_A  in  AW  writeback destination
- WB_WD  in  DW  writeback data
- M_VALID  in  1  multiplier result valid
- M_A  in  AW  multiplier destination
- M_WD  in  DW  multiplier data
- M_READY  out  1  multiplier buffer empty
- F_VALID  in  1  float result valid
- F_A  in  AW  float destination
- F_WD  in  DW  float data
- F_READY  out  1  float buffer empty
- ISSUE_V  in  1  M/F op issued (marks destination pending)
- ISSUE_A  in  AW  issued op destination
- RA1D  in  AW  decode read address 1
- RA2D  in  AW  decode read address 2
- HAZ1  out  1  RA1D pending
- HAZ2  out  1  RA2D pending
- WE3  out  1  register-file write enable
- A3  out  AW  register-file write address
- WD3  out  DW  register-file write data
- WB_STALL  out  1  WB must hold its request this cycle
- DROP_ERR  out  1  sticky: M/F write to index 15 dropped

Behaviour:
- Reset (async, RESETn=0): buffers empty, WE3=0, A3=0, WD3=0, WB_STALL=0, DROP_ERR=0, round-robin pointer rr=0 (M first), scoreboard clear, starvation counters 0. Buffered writes are discarded.
- Skid buffers: M_READY = ~Mfull and F_READY = ~Ffull, both from registers. VALID & READY at a posedge loads the buffer. A buffer granted at an edge cannot reload at that same edge.
- Arbitration at each posedge; candidates are WB_WE, Mfull and Ffull:
  - WB has strict priority.
  - Otherwise M/F round-robin: rr selects the preferred source if both are full. A grant to M sets rr=F; a grant to F sets rr=M.
  - Grant clears the granted buffer.
- Output stage (registered):
  - On a grant with destination <15: WE3=1, A3 and WD3 take the winner's address and data.
  - With no grant: WE3=0; A3 and WD3 hold their values.
  - Latency: WB request to WE3 is 1 cycle; M/F VALID to WE3 is at least 2 cycles.
- Destination 15:
  - WB with A=15: consumed, no write, no error (PC path handles it).
  - M/F with A=15: granted and consumed, WE3=0, DROP_ERR set until reset.
- Scoreboard pend[14:0]:
  - ISSUE_V with ISSUE_A<15 sets the bit.
  - An M/F grant clears its destination bit at the same edge WE3 rises.
  - Set and clear of the same bit at the same edge: set wins.
  - HAZ1 = pend[RA1D], HAZ2 = pend[RA2D], combinational; index 15 always reads 0.
  - A WB write does not touch pend.

Optional Feature:
- Macro: RF_ARB_STARVE_EN
- With macro:
  - Per-source counter increments each cycle the source's buffer is full and not granted; it resets on grant.
  - When a counter reaches STARVE_LIMIT, that source beats WB at the next edge. WB_STALL=1 (decoded from registered counters) for that cycle; WB is not consumed.
  - If both sources are starved, rr decides.
- Without macro: WB_STALL tied 0; strict WB priority.

Decomposition:
- Package rf_arb_pkg: DW, AW, NREG, PC_IDX=15, source enum {SRC_NONE, SRC_WB, SRC_M, SRC_F}.
- Sub-module rf_skid_buf: one-entry valid/ready buffer holding addr and data, instantiated for M and F.

Test Plan:
- WB_WE=1, WB_A=3, WB_WD=0x1234 -> next cycle WE3=1, A3=3, WD3=0x1234; following cycle WE3=0 and A3 still 3.
- M_VALID and F_VALID in the same cycle (A=5/0xAA, A=6/0xBB), no WB -> M_READY=F_READY=0; WE3 shows A3=5 at +2, then A3=6 at +3; both READY back to 1.
- WB held continuously for 10 cycles with M buffered:
  - No macro -> M never granted, WB_STALL=0.
  - With macro, STARVE_LIMIT=4 -> after 4 lost cycles WB_STALL=1 for one cycle and WE3 shows M's destination.
- ISSUE_V with A=7, RA1D=7 -> HAZ1=1. M grant to reg 7 -> HAZ1=0 at the edge WE3 rises. Repeat with ISSUE_V A=7 at the grant edge -> HAZ1 stays 1.
- M write to A=15 -> WE3 stays 0, DROP_ERR=1 until reset. WB write to A=15 -> no write, DROP_ERR unchanged.
- RESETn dropped mid-cycle with both buffers full and pend[7]=1 -> immediately M_READY=F_READY=1, WE3=0, HAZ1=0, DROP_ERR=0.
